// File: rtl/rand_arb_pkg.sv
// Shared definitions for the random-draw arbiter: FSM encoding, default
// parameters and the requester index width helper.
package rand_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT    = 2'd2,
    DELIVER = 2'd3
  } arb_state_e;

  localparam int N_REQ_DEFAULT   = 4;
  localparam int MIN_GAP_DEFAULT = 3;
  localparam int RAND_W_DEFAULT  = 16;

  // Width of a requester index; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int IDX_W_DEFAULT = idx_w(N_REQ_DEFAULT);

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: finds the first set request bit
// searching upward from rr_ptr, wrapping modulo N_REQ.
module rr_pick
  import rand_arb_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEFAULT,
  parameter int IDX_W = IDX_W_DEFAULT
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic             any_req,
  output logic [IDX_W-1:0] winner
);

  // cand[k] is the requester index examined at search position k.
  logic [IDX_W-1:0] cand [N_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_cand
      localparam logic [IDX_W:0] OFFSET = (IDX_W+1)'(gi);
      localparam logic [IDX_W:0] NUM    = (IDX_W+1)'(N_REQ);
      logic [IDX_W:0] sum;
      // rr_ptr is always below N_REQ, so one conditional subtract wraps it.
      assign sum      = {1'b0, rr_ptr} + OFFSET;
      assign cand[gi] = (sum >= NUM) ? IDX_W'(sum - NUM) : sum[IDX_W-1:0];
    end
  endgenerate

  // Scan from the farthest position down so the nearest set bit wins.
  always_comb begin
    any_req = 1'b0;
    winner  = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req[cand[k]]) begin
        any_req = 1'b1;
        winner  = cand[k];
      end
    end
  end

endmodule

// File: rtl/rand_draw_arbiter.sv
// Shares one LFSR random-number generator among N_REQ requesters. Each draw
// pulses gen_request for one cycle, captures gen_num the following cycle and
// hands it to the round-robin winner with a one-cycle ack. A gap counter
// keeps the LFSR free-running between draws so consecutive values differ.
module rand_draw_arbiter
  import rand_arb_pkg::*;
#(
  parameter int N_REQ   = N_REQ_DEFAULT,
  parameter int MIN_GAP = MIN_GAP_DEFAULT,
  parameter int RAND_W  = RAND_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_REQ-1:0]  req,
  output logic [N_REQ-1:0]  ack,
  output logic [RAND_W-1:0] rand_out,
  output logic              busy,
  output logic              gen_request,
  input  logic [RAND_W-1:0] gen_num
);

  localparam int IDX_W = idx_w(N_REQ);
  localparam int GAP_W = $clog2(MIN_GAP + 1);
  localparam logic [GAP_W-1:0] GAP_MAX  = GAP_W'(MIN_GAP);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REQ - 1);

  arb_state_e        state_reg, state_next;
  logic [IDX_W-1:0]  rr_ptr_reg;
  logic [IDX_W-1:0]  grant_idx_reg;
  logic [GAP_W-1:0]  gap_cnt_reg;
  logic              gen_request_reg;
  logic [RAND_W-1:0] rand_out_reg;

  logic              pick_any;
  logic [IDX_W-1:0]  pick_idx;
  logic              gap_ok;
  logic              start_draw;
  logic              gap_counting;

  rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req     (req),
    .rr_ptr  (rr_ptr_reg),
    .any_req (pick_any),
    .winner  (pick_idx)
  );

  assign gap_ok     = (gap_cnt_reg == GAP_MAX);
  assign start_draw = (state_reg == IDLE) && (state_next == ISSUE);
  // The gap only accumulates once the drawn value has been captured, so the
  // LFSR always runs MIN_GAP full cycles past the previous capture point.
  assign gap_counting = !gen_request_reg &&
                        ((state_reg == IDLE) || (state_reg == DELIVER));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic: one draw walks ISSUE -> WAIT -> DELIVER unconditionally.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (pick_any && gap_ok) state_next = ISSUE;
      ISSUE:   state_next = WAIT;
      WAIT:    state_next = DELIVER;
      DELIVER: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output decode: busy for any active state, ack only in DELIVER.
  always_comb begin
    busy = (state_reg != IDLE);
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_ack
      assign ack[gi] = (state_reg == DELIVER) && (grant_idx_reg == IDX_W'(gi));
    end
  endgenerate

  // Gap counter: saturating count of idle generator cycles, cleared per draw.
  always_ff @(posedge clk) begin
    if (rst) begin
      gap_cnt_reg <= '0;
    end else if (start_draw) begin
      gap_cnt_reg <= '0;
    end else if (gap_counting && !gap_ok) begin
      gap_cnt_reg <= gap_cnt_reg + 1'b1;
    end
  end

  // Registered datapath: request pulse, grant latch, value capture, pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      gen_request_reg <= 1'b0;
      grant_idx_reg   <= '0;
      rand_out_reg    <= '0;
      rr_ptr_reg      <= '0;
    end else begin
      gen_request_reg <= (state_next == ISSUE);
      if (start_draw) begin
        grant_idx_reg <= pick_idx;
      end
      if (state_reg == WAIT) begin
        rand_out_reg <= gen_num;
      end
      if (state_reg == DELIVER) begin
        rr_ptr_reg <= (grant_idx_reg == LAST_IDX) ? '0 : grant_idx_reg + 1'b1;
      end
    end
  end

  assign gen_request = gen_request_reg;
  assign rand_out    = rand_out_reg;

endmodule

// File: tb/tb_rand_draw_arbiter.sv
// Self-checking bench for rand_draw_arbiter with a free-running 16-bit LFSR
// generator model. Expected grant indices are queued by each scenario task;
// expected values are queued when gen_request is seen; both are popped on ack.
module tb_rand_draw_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req = 4'b0000;
  logic [3:0]  ack;
  logic [15:0] rand_out;
  logic        busy;
  logic        gen_request;
  logic [15:0] gen_num = 16'h0000;
  logic [15:0] lfsr    = 16'hACE1;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int ack_count = 0;
  int greq_count = 0;
  int last_greq_cyc = -1;
  int rst_cyc = 0;
  logic prev_greq = 1'b0;
  logic [3:0] last_ack = 4'b0000;

  int          exp_idx_q[$];
  logic [15:0] exp_val_q[$];
  int          ack_cyc_q[$];
  logic [15:0] ack_val_q[$];

  always #5 clk = ~clk;

  rand_draw_arbiter #(
    .N_REQ   (4),
    .MIN_GAP (3),
    .RAND_W  (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .ack         (ack),
    .rand_out    (rand_out),
    .busy        (busy),
    .gen_request (gen_request),
    .gen_num     (gen_num)
  );

  // Generator model: free-running Fibonacci LFSR, loads numRand on request.
  always @(posedge clk) begin
    lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    if (gen_request) gen_num <= lfsr;
  end

  // Per-cycle monitor: invariants plus scoreboard pop on every ack.
  always @(negedge clk) begin
    int          idx;
    logic [15:0] val;
    cyc++;
    if (!rst) begin
      n_cmp++;
      if (!$onehot0(ack)) begin
        n_bad++;
        $display("FAIL ack_onehot: got %b, required one-hot or zero", ack);
      end
      n_cmp++;
      if (gen_request && prev_greq) begin
        n_bad++;
        $display("FAIL greq_consecutive: gen_request high two cycles in a row at cycle %0d", cyc);
      end
      if (gen_request || ack != 4'b0000) begin
        n_cmp++;
        if (busy !== 1'b1) begin
          n_bad++;
          $display("FAIL busy_active: got %b, required 1 (greq=%b ack=%b)", busy, gen_request, ack);
        end
      end
      if (gen_request) begin
        greq_count++;
        last_greq_cyc = cyc;
        exp_val_q.push_back(lfsr);
        $display("cycle %0d: gen_request, generator will return %h", cyc, lfsr);
      end
      if (ack != 4'b0000) begin
        ack_count++;
        last_ack = ack;
        ack_cyc_q.push_back(cyc);
        ack_val_q.push_back(rand_out);
        $display("cycle %0d: ack=%b rand_out=%h", cyc, ack, rand_out);
        n_cmp++;
        if (exp_idx_q.size() == 0 || exp_val_q.size() == 0) begin
          n_bad++;
          $display("FAIL ack_unexpected: got ack=%b, required no ack", ack);
        end else begin
          idx = exp_idx_q.pop_front();
          val = exp_val_q.pop_front();
          if (ack !== 4'(1 << idx)) begin
            n_bad++;
            $display("FAIL ack_index: got %b, required %b", ack, 4'(1 << idx));
          end
          n_cmp++;
          if (rand_out !== val) begin
            n_bad++;
            $display("FAIL rand_value: got %h, required %h", rand_out, val);
          end
        end
      end
    end
    prev_greq = gen_request;
  end

  task automatic clear_board();
    exp_idx_q.delete();
    exp_val_q.delete();
    ack_cyc_q.delete();
    ack_val_q.delete();
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    req = 4'b0000;
    repeat (2) @(negedge clk);
    #1;
    rst = 1'b0;
    clear_board();
    rst_cyc = cyc;
  endtask

  task automatic wait_acks(input int target, input int budget, output bit timed_out);
    timed_out = 1'b1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #1;
      if (ack_count >= target) begin
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  task automatic wait_greq(input int target, input int budget, output bit timed_out);
    timed_out = 1'b1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #1;
      if (greq_count >= target) begin
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req = 4'b0000;
    repeat (3) @(negedge clk);
    #1;
    n_cmp++; if (ack !== 4'b0000) begin n_bad++; $display("FAIL reset_ack: got %b, required 0000", ack); end
    n_cmp++; if (gen_request !== 1'b0) begin n_bad++; $display("FAIL reset_greq: got %b, required 0", gen_request); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b, required 0", busy); end
    n_cmp++; if (rand_out !== 16'h0000) begin n_bad++; $display("FAIL reset_rand: got %h, required 0000", rand_out); end
    rst = 1'b0;
    clear_board();
    rst_cyc = cyc;
    $display("reset checked at cycle %0d", cyc);
  endtask

  task automatic test_first_draw();
    bit to;
    int g0;
    exp_idx_q.push_back(0);
    req = 4'b0001;
    wait_greq(greq_count + 1, 30, to);
    n_cmp++; if (to) begin n_bad++; $display("FAIL first_greq_timeout: got none, required gen_request"); end
    n_cmp++;
    if (last_greq_cyc != rst_cyc + 4) begin
      n_bad++;
      $display("FAIL first_greq_latency: got %0d, required %0d", last_greq_cyc - rst_cyc, 4);
    end
    wait_acks(ack_count + 1, 30, to);
    req = 4'b0000;
    n_cmp++; if (to) begin n_bad++; $display("FAIL first_ack_timeout: got none, required ack"); end
    n_cmp++;
    if (ack_cyc_q.size() != 1 || ack_cyc_q[0] != rst_cyc + 6) begin
      n_bad++;
      $display("FAIL first_ack_latency: got %0d acks, required one ack at +6", ack_cyc_q.size());
    end
    g0 = greq_count;
    repeat (10) @(negedge clk);
    #1;
    n_cmp++; if (greq_count != g0) begin n_bad++; $display("FAIL first_single_pulse: got %0d extra, required 0", greq_count - g0); end
  endtask

  task automatic test_round_robin();
    bit to;
    int base;
    apply_reset();
    exp_idx_q.push_back(0); exp_idx_q.push_back(1); exp_idx_q.push_back(2);
    exp_idx_q.push_back(3); exp_idx_q.push_back(0);
    base = ack_count;
    req = 4'b1111;
    wait_acks(base + 5, 200, to);
    req = 4'b0000;
    n_cmp++; if (to) begin n_bad++; $display("FAIL rr_timeout: got %0d acks, required 5", ack_count - base); end
    n_cmp++;
    if (ack_cyc_q.size() != 5) begin
      n_bad++;
      $display("FAIL rr_ack_count: got %0d, required 5", ack_cyc_q.size());
    end else begin
      for (int i = 1; i < 5; i++) begin
        n_cmp++;
        if (ack_cyc_q[i] - ack_cyc_q[i-1] != 6) begin
          n_bad++;
          $display("FAIL rr_spacing: got %0d, required 6", ack_cyc_q[i] - ack_cyc_q[i-1]);
        end
      end
      for (int i = 0; i < 5; i++) begin
        for (int j = i + 1; j < 5; j++) begin
          n_cmp++;
          if (ack_val_q[i] === ack_val_q[j]) begin
            n_bad++;
            $display("FAIL rr_distinct: got %h twice, required distinct values", ack_val_q[i]);
          end
        end
      end
    end
    repeat (10) @(negedge clk);
    #1;
    n_cmp++; if (ack_count != base + 5) begin n_bad++; $display("FAIL rr_no_extra: got %0d acks, required 5", ack_count - base); end
  endtask

  task automatic test_rr_wrap();
    bit to;
    apply_reset();
    exp_idx_q.push_back(1);
    req = 4'b0010;
    wait_acks(ack_count + 1, 40, to);
    n_cmp++; if (to || last_ack !== 4'b0010) begin n_bad++; $display("FAIL wrap_setup: got %b, required 0010", last_ack); end
    exp_idx_q.push_back(0);
    req = 4'b0011;
    wait_acks(ack_count + 1, 40, to);
    n_cmp++; if (to || last_ack !== 4'b0001) begin n_bad++; $display("FAIL wrap_grant0: got %b, required 0001", last_ack); end
    exp_idx_q.push_back(1);
    req = 4'b0010;
    wait_acks(ack_count + 1, 40, to);
    n_cmp++; if (to || last_ack !== 4'b0010) begin n_bad++; $display("FAIL wrap_grant1: got %b, required 0010", last_ack); end
    exp_idx_q.push_back(3);
    req = 4'b1000;
    wait_acks(ack_count + 1, 40, to);
    req = 4'b0000;
    n_cmp++; if (to || last_ack !== 4'b1000) begin n_bad++; $display("FAIL wrap_grant3: got %b, required 1000", last_ack); end
  endtask

  task automatic test_reset_mid_draw();
    bit to;
    int base;
    apply_reset();
    exp_idx_q.push_back(0);
    req = 4'b0001;
    wait_acks(ack_count + 1, 40, to);
    req = 4'b0000;
    n_cmp++; if (to) begin n_bad++; $display("FAIL abort_setup: got no ack, required ack"); end
    exp_idx_q.push_back(1);
    req = 4'b0010;
    wait_greq(greq_count + 1, 40, to);
    n_cmp++; if (to) begin n_bad++; $display("FAIL abort_greq_timeout: got none, required gen_request"); end
    rst = 1'b1;
    req = 4'b0000;
    base = ack_count;
    @(negedge clk);
    #1;
    n_cmp++; if (gen_request !== 1'b0) begin n_bad++; $display("FAIL abort_greq: got %b, required 0", gen_request); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy: got %b, required 0", busy); end
    n_cmp++; if (rand_out !== 16'h0000) begin n_bad++; $display("FAIL abort_rand: got %h, required 0000", rand_out); end
    @(negedge clk);
    #1;
    rst = 1'b0;
    clear_board();
    rst_cyc = cyc;
    n_cmp++; if (ack_count != base) begin n_bad++; $display("FAIL abort_no_ack: got %0d acks, required 0", ack_count - base); end
    exp_idx_q.push_back(1);
    req = 4'b0010;
    wait_greq(greq_count + 1, 40, to);
    n_cmp++;
    if (to || last_greq_cyc != rst_cyc + 4) begin
      n_bad++;
      $display("FAIL abort_regap: got %0d, required 4", last_greq_cyc - rst_cyc);
    end
    wait_acks(ack_count + 1, 40, to);
    req = 4'b0000;
    n_cmp++; if (to || ack_count != base + 1 || last_ack !== 4'b0010) begin n_bad++; $display("FAIL abort_redraw: got %b, required 0010", last_ack); end
  endtask

  task automatic test_withdraw();
    bit to;
    int a0;
    int g0;
    apply_reset();
    exp_idx_q.push_back(2);
    req = 4'b0100;
    wait_greq(greq_count + 1, 40, to);
    n_cmp++; if (to) begin n_bad++; $display("FAIL withdraw_greq_timeout: got none, required gen_request"); end
    @(negedge clk);
    #1;
    req = 4'b0000;
    wait_acks(ack_count + 1, 10, to);
    n_cmp++; if (to || last_ack !== 4'b0100) begin n_bad++; $display("FAIL withdraw_ack: got %b, required 0100", last_ack); end
    a0 = ack_count;
    g0 = greq_count;
    repeat (15) @(negedge clk);
    #1;
    n_cmp++; if (ack_count != a0 || greq_count != g0) begin n_bad++; $display("FAIL withdraw_idle: got %0d extra draws, required 0", greq_count - g0); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL withdraw_busy: got %b, required 0", busy); end
  endtask

  initial begin
    test_reset();
    test_first_draw();
    test_round_robin();
    test_rr_wrap();
    test_reset_mid_draw();
    test_withdraw();
    repeat (2) @(negedge clk);
    #1;
    n_cmp++;
    if (exp_idx_q.size() != 0) begin
      n_bad++;
      $display("FAIL leftover_grants: got %0d pending, required 0", exp_idx_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
